// File: rtl/rv32m_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 opcodes, FSM
// encodings and operand-class helpers.
package rv32m_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/rv32m_muldiv_if.sv
// Issue/result bundle between the execute stage and the M-extension unit.
interface rv32m_muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a_decode;
  logic [XLEN-1:0] b_decode;
  logic [4:0]      a_rs_idx;
  logic [4:0]      b_rs_idx;
  logic [4:0]      regfile_rd_idx;
  logic [XLEN-1:0] regfile_rd_val;
  logic [4:0]      rd_in;
  logic            cancel;
  logic            busy;
  logic            done;
  logic [4:0]      rd;
  logic [XLEN-1:0] c;

  modport master (
    output start, funct3, a_decode, b_decode, a_rs_idx, b_rs_idx,
           regfile_rd_idx, regfile_rd_val, rd_in, cancel,
    input  busy, done, rd, c
  );

  modport slave (
    input  start, funct3, a_decode, b_decode, a_rs_idx, b_rs_idx,
           regfile_rd_idx, regfile_rd_val, rd_in, cancel,
    output busy, done, rd, c
  );
endinterface

// File: rtl/rv32m_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide
// on the {acc, shreg} pair.
module rv32m_iter_step #(
  parameter int XLEN = 32
) (
  input  logic            div_mode,
  input  logic [XLEN:0]   acc,
  input  logic [XLEN-1:0] shreg,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN:0]   acc_nx,
  output logic [XLEN-1:0] shreg_nx
);
  logic [XLEN:0] sum, sh, diff;

  always_comb begin
    sum      = acc + (shreg[0] ? {1'b0, opnd} : '0);
    sh       = {acc[XLEN-1:0], shreg[XLEN-1]};
    diff     = sh - {1'b0, opnd};
    acc_nx   = {1'b0, sum[XLEN:1]};
    shreg_nx = {sum[0], shreg[XLEN-1:1]};
    if (div_mode) begin
      // Remainder stays below the divisor, so acc never needs its top bit here.
      if (sh >= {1'b0, opnd}) begin
        acc_nx   = diff;
        shreg_nx = {shreg[XLEN-2:0], 1'b1};
      end else begin
        acc_nx   = sh;
        shreg_nx = {shreg[XLEN-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit. Define RV32M_FAST_MUL_EN to compute
// MUL* with a single-cycle signed product instead of the shift-add loop.
module rv32m_muldiv
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          reset_n,
  rv32m_muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [XLEN:0]   acc_q, acc_nx;
  logic [XLEN-1:0] shreg_q, shreg_nx, opnd_q;
  logic            neg_q, negr_q;
  logic [XLEN-1:0] res_q, c_q, res_d;

  logic [XLEN-1:0] a_op, b_op, a_mag, b_mag;
  logic            sa, sb, div_op, b_zero, div_ovf, take_fix, done_w;

  // Writeback bypass is only looked at on the issue cycle.
  assign a_op = (bus.a_rs_idx == bus.regfile_rd_idx && bus.regfile_rd_idx != 5'd0)
                ? bus.regfile_rd_val : bus.a_decode;
  assign b_op = (bus.b_rs_idx == bus.regfile_rd_idx && bus.regfile_rd_idx != 5'd0)
                ? bus.regfile_rd_val : bus.b_decode;

  assign sa      = is_signed_a(bus.funct3) & a_op[XLEN-1];
  assign sb      = is_signed_b(bus.funct3) & b_op[XLEN-1];
  assign a_mag   = sa ? -a_op : a_op;
  assign b_mag   = sb ? -b_op : b_op;
  assign div_op  = is_div(bus.funct3);
  assign b_zero  = (b_op == '0);
  assign div_ovf = is_signed_a(bus.funct3) && (a_op == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (b_op == '1);

`ifdef RV32M_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = (2*XLEN)'($signed({is_signed_a(bus.funct3) & a_op[XLEN-1], a_op}) *
                              $signed({is_signed_b(bus.funct3) & b_op[XLEN-1], b_op}));
  assign take_fix  = div_op ? (b_zero | div_ovf) : 1'b1;
`else
  assign take_fix  = div_op & (b_zero | div_ovf);
`endif

  rv32m_iter_step #(.XLEN(XLEN)) u_step (
    .div_mode (is_div(f3_q)),
    .acc      (acc_q),
    .shreg    (shreg_q),
    .opnd     (opnd_q),
    .acc_nx   (acc_nx),
    .shreg_nx (shreg_nx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = take_fix ? ST_FIX : ST_CALC;
      ST_CALC: begin
        if (bus.cancel)        state_d = ST_IDLE;
        else if (cnt_q == '0)  state_d = ST_FIX;
      end
      ST_FIX:  state_d = bus.cancel ? ST_IDLE : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
    endcase
  end

  // Sign fix-up and result select; special cases were pre-loaded so they
  // fall through here with no negation.
  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0]   q_f, r_f;
  always_comb begin
    prod_f = neg_q  ? -{acc_q[XLEN-1:0], shreg_q} : {acc_q[XLEN-1:0], shreg_q};
    q_f    = neg_q  ? -shreg_q : shreg_q;
    r_f    = negr_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    res_d  = '0;
    unique case (f3_q)
      F3_MUL:                       res_d = prod_f[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_d = prod_f[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              res_d = q_f;
      F3_REM, F3_REMU:              res_d = r_f;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      shreg_q <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
      c_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.start) begin
          f3_q   <= bus.funct3;
          rd_q   <= bus.rd_in;
          cnt_q  <= CNT_W'(XLEN-1);
          opnd_q <= div_op ? b_mag : a_mag;
          neg_q  <= 1'b0;
          negr_q <= 1'b0;
          if (div_op && b_zero) begin
            acc_q   <= {1'b0, a_op};
            shreg_q <= '1;
          end else if (div_op && div_ovf) begin
            acc_q   <= '0;
            shreg_q <= a_op;
          end else if (div_op) begin
            acc_q   <= '0;
            shreg_q <= a_mag;
            neg_q   <= sa ^ sb;
            negr_q  <= sa;
          end else begin
`ifdef RV32M_FAST_MUL_EN
            acc_q   <= {1'b0, fast_prod[2*XLEN-1:XLEN]};
            shreg_q <= fast_prod[XLEN-1:0];
`else
            acc_q   <= '0;
            shreg_q <= b_mag;
            neg_q   <= sa ^ sb;
`endif
          end
        end
        ST_CALC: begin
          acc_q   <= acc_nx;
          shreg_q <= shreg_nx;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        ST_FIX:  res_q <= res_d;
        ST_DONE: if (!bus.cancel) c_q <= res_q;
      endcase
    end
  end

  assign done_w   = (state_q == ST_DONE) && !bus.cancel;
  assign bus.busy = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign bus.done = done_w;
  assign bus.rd   = done_w ? rd_q : 5'd0;
  assign bus.c    = done_w ? res_q : c_q;
endmodule

// File: tb/tb_rv32m_muldiv.sv
// Self-checking bench for rv32m_muldiv: vector table through a scoreboard,
// plus hand sequences for cancel, ignored start, mid-op reset and bypass.
module tb_rv32m_muldiv;
  localparam int XLEN = 32;
`ifdef RV32M_FAST_MUL_EN
  localparam int LM = 2;
`else
  localparam int LM = 34;
`endif
  localparam int LD = 34;
  localparam int LS = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rv32m_muldiv_if #(.XLEN(XLEN)) bus ();
  rv32m_muldiv #(.XLEN(XLEN)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] c;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[16];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cur_lat = 0;
  logic [31:0] last_c = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cur_lat++;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [4:0] ai, input logic [4:0] bi,
                       input logic [4:0] wi, input logic [31:0] wv, input logic cx,
                       input bit push, input logic [31:0] exp, input int lat);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.a_decode = a; bus.b_decode = b;
    bus.rd_in = rd; bus.a_rs_idx = ai; bus.b_rs_idx = bi;
    bus.regfile_rd_idx = wi; bus.regfile_rd_val = wv; bus.cancel = cx;
    if (push) begin
      e.c = exp; e.rd = rd; e.lat = lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    cur_lat = 1;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.a_rs_idx = '0; bus.b_rs_idx = '0;
    bus.regfile_rd_idx = '0; bus.regfile_rd_val = '0;
    bus.funct3 = 3'd0; bus.a_decode = '0; bus.b_decode = '0; bus.rd_in = '0;
  endtask

  task automatic wait_done(input string nm);
    exp_t e;
    while (!bus.done && cur_lat < 100) tick();
    if (!bus.done) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: no done after %0d cycles", nm, cur_lat);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_unexpected: done with c=0x%08h, nothing expected", nm, bus.c);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_c"}, bus.c, e.c);
      chk({nm, "_rd"}, 32'(bus.rd), 32'(e.rd));
      chk({nm, "_lat"}, 32'(cur_lat), 32'(e.lat));
      chk({nm, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      last_c = e.c;
    end
  endtask

  task automatic count_dones(input string nm, input int cycles);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done) n++;
    end
    chk(nm, 32'(n), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, LM};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, LM};
    vecs[2]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, LM};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, LM};
    vecs[4]  = '{3'd3, 32'h80000000, 32'd2,        5'd5,  32'h00000001, LM};
    vecs[5]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, LD};
    vecs[6]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, LD};
    vecs[7]  = '{3'd5, 32'd100,      32'd7,        5'd8,  32'd14,       LD};
    vecs[8]  = '{3'd7, 32'd100,      32'd7,        5'd9,  32'd2,        LD};
    vecs[9]  = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, LD};
    vecs[10] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd11, 32'd1,        LD};
    vecs[11] = '{3'd5, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, LS};
    vecs[12] = '{3'd7, 32'd5,        32'd0,        5'd13, 32'd5,        LS};
    vecs[13] = '{3'd6, 32'hFFFFFFFB, 32'd0,        5'd14, 32'hFFFFFFFB, LS};
    vecs[14] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, LS};
    vecs[15] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        LS};

    bus.start = 1'b0; bus.funct3 = '0; bus.a_decode = '0; bus.b_decode = '0;
    bus.a_rs_idx = '0; bus.b_rs_idx = '0; bus.regfile_rd_idx = '0;
    bus.regfile_rd_val = '0; bus.rd_in = '0; bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_rd",   32'(bus.rd),   32'd0);
    chk("reset_c",    bus.c,         32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0,
            1'b1, vecs[i].exp, vecs[i].lat);
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd1);
      wait_done($sformatf("vec%0d", i));
    end

    // cancel mid-divide, then reissue straight away
    issue(3'd4, 32'd100, 32'd7, 5'd20, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, '0, 0);
    while (cur_lat < 10) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("cancel_busy", 32'(bus.busy), 32'd0);
    chk("cancel_done", 32'(bus.done), 32'd0);
    chk("cancel_rd",   32'(bus.rd),   32'd0);
    chk("cancel_c",    bus.c,         last_c);
    issue(3'd4, 32'd100, 32'hFFFFFFF9, 5'd21, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0,
          1'b1, 32'hFFFFFFF2, LD);
    wait_done("after_cancel");

    // start while busy is ignored
    issue(3'd5, 32'd100, 32'd7, 5'd22, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd14, LD);
    tick(); tick();
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.a_decode = 32'd1; bus.b_decode = 32'd1;
    bus.rd_in = 5'd1;
    tick();
    bus.start = 1'b0;
    wait_done("busy_start");
    count_dones("busy_start_no_extra_done", 40);

    // cancel in IDLE does not block a same-cycle start
    issue(3'd5, 32'd81, 32'd9, 5'd23, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd9, LD);
    wait_done("idle_cancel");

    // synchronous reset in the middle of an op
    issue(3'd5, 32'd100, 32'd7, 5'd24, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, '0, 0);
    while (cur_lat < 5) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midreset_busy", 32'(bus.busy), 32'd0);
    chk("midreset_done", 32'(bus.done), 32'd0);
    chk("midreset_rd",   32'(bus.rd),   32'd0);
    chk("midreset_c",    bus.c,         32'd0);
    count_dones("midreset_no_done", 40);

    // writeback bypass on either operand; index 0 never bypasses
    issue(3'd5, 32'd1, 32'd10, 5'd25, 5'd5, 5'd0, 5'd5, 32'd100, 1'b0, 1'b1, 32'd10, LD);
    wait_done("bypass_a");
    issue(3'd5, 32'd1, 32'd10, 5'd26, 5'd0, 5'd0, 5'd0, 32'd100, 1'b0, 1'b1, 32'd0, LD);
    wait_done("bypass_idx0");
    issue(3'd5, 32'd100, 32'd1, 5'd27, 5'd0, 5'd7, 5'd7, 32'd4, 1'b0, 1'b1, 32'd25, LD);
    wait_done("bypass_b");
    @(negedge clk);
    chk("c_holds", bus.c, 32'd25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
